vc_test_fixed_delay_source: RTL

// Test-harness message source that injects a fixed number of idle cycles

---
 rtl/vc_test_fixed_delay_source.sv | 99 +++++++++
 1 files changed

// File: rtl/vc_test_fixed_delay_source.sv
// -----------------------------------------------------------------------------
// vc_test_fixed_delay_source
//
// Test-harness message source. Before it offers each message downstream, it
// waits a programmable number of idle cycles. Messages are preloaded into the
// internal array m[] by hierarchical write from the testbench. They are sent in
// index order over a val/rdy handshake.
//
// Parameters
//   p_msg_nbits  width of one message
//   p_num_msgs   depth of m[]
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous reset, active low (0 = in reset)
//   delay     in   idle cycles before each message (sampled live)
//   num_msgs  in   count of valid entries in m[], clamped to p_num_msgs
//   val       out  message valid
//   rdy       in   downstream ready
//   msg       out  current message m[idx], zero once idx runs off the array
//   done      out  all num_msgs messages have been transferred
// -----------------------------------------------------------------------------
module vc_test_fixed_delay_source #(
  parameter int unsigned p_msg_nbits = 1,
  parameter int unsigned p_num_msgs  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            delay,
  input  logic [31:0]            num_msgs,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  // The extra index bit lets idx reach p_num_msgs itself, which is the
  // "everything sent" value when num_msgs is clamped.
  localparam int unsigned IDX_W    = $clog2(p_num_msgs) + 1;
  localparam int unsigned ADDR_W   = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [31:0] MAX_MSGS = 32'(p_num_msgs);

  // NOTE: the message store has no reset and no write port here. Its contents
  // belong to the testbench, which fills it by hierarchical write. Resetting
  // it would wipe a preload that was made while reset was held.
  logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

  logic [IDX_W-1:0] idx;      // next message to send
  logic [31:0]      cnt;      // idle cycles elapsed since reset/last transfer
  logic [31:0]      lim;      // effective message count
  logic [31:0]      idx_ext;  // idx widened for 32-bit compares
  logic             xfer;     // handshake completes this cycle

  // ---------------------------------------------------------------------------
  // Derived outputs. val depends only on state and on the live delay/num_msgs
  // inputs, never on rdy, so there is no rdy-to-val path through this block.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    lim     = (num_msgs > MAX_MSGS) ? MAX_MSGS : num_msgs;
    idx_ext = 32'(idx);
    msg     = '0;

    done = (idx_ext >= lim);
    // cnt is already zero while reset is low. The explicit gate keeps val low
    // during reset even when delay is zero.
    val  = reset && !done && (cnt >= delay);
    xfer = val && rdy;

    if (idx_ext < MAX_MSGS) begin
      msg = m[idx[ADDR_W-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing state.
  // - A transfer advances idx and restarts the idle count.
  // - Otherwise cnt climbs toward delay and stops there, so it never wraps.
  //   Because it stops at the current delay, raising delay later makes val
  //   wait again.
  // - Once done, both registers freeze whatever rdy does. xfer is already
  //   low then, because val needs !done.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      cnt <= '0;
    end else if (xfer) begin
      idx <= idx + IDX_W'(1);
      cnt <= '0;
    end else if (!done && (cnt < delay)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule
